// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, fetches over req/ack and
// hands instructions to decode over valid/ready with redirect and halt.
module fetch_sequencer #(
  parameter int          PC_WIDTH = 14,
  parameter int unsigned RESET_PC = 0,
  parameter int          MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  output logic                instr_valid,
  output logic [31:0]         instr,
  output logic [PC_WIDTH-1:0] instr_pc,
  input  logic                instr_ready,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  input  logic                halt,
  output logic                busy,
  output logic                halted,
  output logic                timeout_err,
  output logic [15:0]         fetch_count
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);
  localparam logic [PC_WIDTH-1:0] PC_RST = PC_WIDTH'(RESET_PC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_VALID,
    S_HALTED,
    S_ERROR
  } state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic [31:0]         instr_q, instr_d;
  logic [WW-1:0]       wait_q, wait_d;
  logic [15:0]         count_q, count_d;
  logic                req_q, req_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                halted_q, halted_d;
  logic                err_q, err_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_pc_d = instr_pc_q;
    instr_d    = instr_q;
    wait_d     = wait_q;
    count_d    = count_q;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc_q;
          pc_d       = pc_q + PC_WIDTH'(1);
          wait_d     = '0;
          state_d    = S_VALID;
        end else begin
          wait_d = wait_q + WW'(1);
          // an ack in the last allowed cycle still wins
          if (wait_q == WAIT_LAST)
            state_d = S_ERROR;
        end
      end
      S_VALID: begin
        if (instr_ready) begin
          count_d = count_q + 16'd1;
          if (redirect)
            pc_d = redirect_pc;
          state_d = halt ? S_HALTED : S_FETCH;
        end
      end
      S_HALTED: state_d = S_HALTED;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_d    = 1'b0;
    valid_d  = 1'b0;
    busy_d   = 1'b0;
    halted_d = 1'b0;
    err_d    = 1'b0;
    unique case (1'b1)
      (state_d == S_FETCH): begin
        req_d  = 1'b1;
        busy_d = 1'b1;
      end
      (state_d == S_VALID): begin
        valid_d = 1'b1;
        busy_d  = 1'b1;
      end
      (state_d == S_HALTED): halted_d = 1'b1;
      (state_d == S_ERROR):  err_d    = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= PC_RST;
      instr_pc_q <= '0;
      instr_q    <= '0;
      wait_q     <= '0;
      count_q    <= '0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_pc_q <= instr_pc_d;
      instr_q    <= instr_d;
      wait_q     <= wait_d;
      count_q    <= count_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      halted_q   <= halted_d;
      err_q      <= err_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign timeout_err = err_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: sequencing, redirect, timeout,
// halt, PC wrap and asynchronous reset.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ack_en;
  logic        ready;
  logic        redir;
  logic [13:0] redir_pc;
  logic        hlt;

  logic        req0, valid0, busy0, halted0, err0;
  logic [13:0] addr0, ipc0;
  logic [31:0] instr0, rdata0;
  logic [15:0] cnt0;

  logic        req1, valid1, busy1, halted1, err1;
  logic [13:0] addr1, ipc1;
  logic [31:0] instr1, rdata1;
  logic [15:0] cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rdata0 = 32'hA0 + {18'd0, addr0};
  assign rdata1 = 32'hB0 + {18'd0, addr1};

  fetch_sequencer #(.PC_WIDTH(14), .RESET_PC(0), .MAX_WAIT(15)) u0 (
    .clk(clk), .rst_n(rst_n),
    .imem_req(req0), .imem_addr(addr0),
    .imem_ack(ack_en), .imem_rdata(rdata0),
    .instr_valid(valid0), .instr(instr0), .instr_pc(ipc0),
    .instr_ready(ready), .redirect(redir), .redirect_pc(redir_pc),
    .halt(hlt), .busy(busy0), .halted(halted0),
    .timeout_err(err0), .fetch_count(cnt0)
  );

  fetch_sequencer #(.PC_WIDTH(14), .RESET_PC(16383), .MAX_WAIT(15)) u1 (
    .clk(clk), .rst_n(rst_n),
    .imem_req(req1), .imem_addr(addr1),
    .imem_ack(1'b1), .imem_rdata(rdata1),
    .instr_valid(valid1), .instr(instr1), .instr_pc(ipc1),
    .instr_ready(1'b1), .redirect(1'b0), .redirect_pc(14'd0),
    .halt(1'b0), .busy(busy1), .halted(halted1),
    .timeout_err(err1), .fetch_count(cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    ack_en   = 1'b1;
    ready    = 1'b1;
    redir    = 1'b0;
    redir_pc = '0;
    hlt      = 1'b0;
    step();
    chk("rst_req", req0, 0);
    chk("rst_valid", valid0, 0);
    chk("rst_instr", instr0, 0);
    chk("rst_ipc", ipc0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_halted", halted0, 0);
    chk("rst_err", err0, 0);
    chk("rst_cnt", cnt0, 0);
    chk("rst_addr", addr0, 0);
    chk("rst_addr1", addr1, 14'h3FFF);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      step();
      chk("seq_req", req0, 1);
      chk("seq_addr", addr0, i);
      chk("seq_busy", busy0, 1);
      if (i == 0) chk("wrap_addr_first", addr1, 14'h3FFF);
      if (i == 1) chk("wrap_addr_next", addr1, 0);
      step();
      chk("seq_valid", valid0, 1);
      chk("seq_req_low", req0, 0);
      chk("seq_instr", instr0, 32'hA0 + i);
      chk("seq_ipc", ipc0, i);
      if (i == 0) chk("wrap_ipc", ipc1, 14'h3FFF);
      if (i == 3) begin
        redir    = 1'b1;
        redir_pc = 14'd13;
      end
    end
    step();
    redir = 1'b0;
    chk("cnt4", cnt0, 4);
    chk("redir_addr", addr0, 13);
    chk("redir_req", req0, 1);

    step();
    chk("v13_ipc", ipc0, 13);
    chk("v13_instr", instr0, 32'hAD);
    ready = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k == 10) begin
        redir    = 1'b1;
        redir_pc = 14'd5;
      end
      if (k == 11) redir = 1'b0;
      step();
      chk("hold_valid", valid0, 1);
      chk("hold_ipc", ipc0, 13);
      chk("hold_instr", instr0, 32'hAD);
      chk("hold_err", err0, 0);
    end
    chk("hold_cnt", cnt0, 4);
    ready  = 1'b1;
    redir  = 1'b0;
    ack_en = 1'b0;
    step();
    chk("ign_redir_addr", addr0, 14);
    chk("cnt5", cnt0, 5);

    repeat (14) step();
    chk("w15_req", req0, 1);
    ack_en = 1'b1;
    step();
    chk("w15_valid", valid0, 1);
    chk("w15_err", err0, 0);
    chk("w15_ipc", ipc0, 14);
    chk("w15_instr", instr0, 32'hAE);
    ack_en = 1'b0;
    step();
    chk("w16_addr", addr0, 15);
    chk("cnt6", cnt0, 6);
    repeat (14) step();
    chk("w16_pre_err", err0, 0);
    chk("w16_pre_req", req0, 1);
    step();
    chk("to_err", err0, 1);
    chk("to_req", req0, 0);
    chk("to_busy", busy0, 0);
    chk("to_addr", addr0, 15);
    ack_en = 1'b1;
    repeat (3) step();
    chk("late_err", err0, 1);
    chk("late_valid", valid0, 0);
    chk("late_req", req0, 0);
    chk("late_addr", addr0, 15);
    chk("late_cnt", cnt0, 6);

    rst_n = 1'b0;
    #1;
    chk("rst2_err", err0, 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("h_addr", addr0, i);
      step();
      chk("h_ipc", ipc0, i);
      if (i == 6) begin
        hlt      = 1'b1;
        redir    = 1'b1;
        redir_pc = 14'd2;
      end
    end
    step();
    hlt   = 1'b0;
    redir = 1'b0;
    chk("halted", halted0, 1);
    chk("halt_addr", addr0, 2);
    chk("halt_req", req0, 0);
    chk("halt_busy", busy0, 0);
    chk("halt_cnt", cnt0, 7);
    repeat (5) step();
    chk("halt_req_stay", req0, 0);
    chk("halt_stay", halted0, 1);

    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      step();
    end
    step();
    chk("mid_addr7", addr0, 7);
    chk("mid_req", req0, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", req0, 0);
    chk("mid_rst_addr", addr0, 0);
    chk("mid_rst_cnt", cnt0, 0);
    chk("mid_rst_instr", instr0, 0);
    chk("mid_rst_busy", busy0, 0);
    step();
    chk("mid_rst_valid", valid0, 0);
    chk("mid_rst_ipc", ipc0, 0);
    rst_n = 1'b1;
    step();
    chk("restart_req", req0, 1);
    chk("restart_addr", addr0, 0);
    step();
    chk("restart_ipc", ipc0, 0);
    chk("restart_instr", instr0, 32'hA0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle instruction-fetch controller that owns the architectural PC register and sequences it around the combinational `program_counter` next-PC datapath. It issues word-addressed fetch requests to instruction memory over a req/ack handshake and presents each fetched instruction to decode over a valid/ready handshake. It then loads the PC with either PC+1 or the redirect target that decode/`program_counter` supplies with the handshake. Halt and fetch-timeout handling are included.

## Interface

- `PC_WIDTH`, 14: PC / instruction-memory word-address width.
- `RESET_PC`, 0: PC value loaded on reset.
- `MAX_WAIT`, 15: maximum FETCH cycles without `imem_ack` before error (≥1).
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `imem_req`  out  1  fetch request (registered).
- `imem_addr`  out  PC_WIDTH  fetch word address; always equals the PC register.
- `imem_ack`  in  1  memory returns data this cycle; ignored unless `imem_req`=1.
- `imem_rdata`  in  32  instruction word, sampled when `imem_req`&`imem_ack`.
- `instr_valid`  out  1  fetched instruction held for decode.
- `instr`  out  32  held instruction word.
- `instr_pc`  out  PC_WIDTH  address the held instruction came from.
- `instr_ready`  in  1  decode accepts the instruction this cycle.
- `redirect`  in  1  qualified by the handshake: next PC is `redirect_pc` (jump/jal/jr/taken beq/bne).
- `redirect_pc`  in  PC_WIDTH  target from `program_counter` `new_pc`.
- `halt`  in  1  qualified by the handshake: stop fetching after this instruction.
- `busy`  out  1  high in FETCH or VALID.
- `halted`  out  1  high in HALTED.
- `timeout_err`  out  1  high in ERROR.
- `fetch_count`  out  16  number of completed decode handshakes, wraps modulo 2^16.

## Operation

- States: IDLE, FETCH, VALID, HALTED, ERROR. Reset state IDLE.
- Reset values: `pc`=RESET_PC, `imem_req`=0, `instr_valid`=0, `instr`=0, `instr_pc`=0, `busy`=0, `halted`=0, `timeout_err`=0, `fetch_count`=0, `wait_cnt`=0.
- IDLE: outputs idle. Next edge → FETCH unconditionally.
- FETCH: `imem_req`=1, `imem_addr`=pc. On an edge with `imem_ack`=1: `instr`←`imem_rdata`, `instr_pc`←pc, pc←(pc+1) mod 2^PC_WIDTH, `wait_cnt`←0, → VALID. Without ack: `wait_cnt`+1. If ack is absent in all of FETCH cycles 1..MAX_WAIT → ERROR. An ack in cycle MAX_WAIT is accepted.
- VALID: `instr_valid`=1, `imem_req`=0. `instr`/`instr_pc` stay stable until the handshake (`instr_valid`&`instr_ready`). At the handshake:
  - `fetch_count`+1.
  - If `redirect`, pc←`redirect_pc`; otherwise pc keeps the already-incremented value.
  - If `halt` → HALTED; otherwise → FETCH.
  - `redirect` and `halt` may both be 1: pc is updated and the state goes to HALTED.
- `redirect`/`halt` outside a handshake cycle: ignored, no effect on pc or state.
- HALTED: `halted`=1, no requests. Only reset exits.
- ERROR: `timeout_err`=1, `imem_req`=0, pc frozen at the faulting address. Only reset exits.
- PC wrap: 2^PC_WIDTH−1 + 1 → 0. No flag raised.
- Reset asserted in any state: all registers take reset values immediately (asynchronous), including mid-FETCH with a pending ack. Any in-flight data is discarded.

## Timing

- All outputs are registered/state-decoded. There are no combinational paths from inputs to outputs.
- Ack at edge N (req high) → `instr_valid`=1 from N+1.
- Handshake at edge M → `imem_req`=1 with the new `imem_addr` from M+1.
- First request: one cycle in IDLE after `rst_n` deasserts, then `imem_req`=1.
- Peak throughput with zero-wait memory and `instr_ready` tied high: 1 instruction per 2 cycles.
- `instr_ready` may be held low indefinitely in VALID. The state holds and no timeout applies.

## Test plan

- Reset, zero-wait ack, `imem_rdata`=0xA0+addr, ready=1, no redirect:
  - Required: `imem_addr` sequence 0,1,2,3.
  - Required: `instr_pc` matches `instr`, with `instr_valid` pulses every 2 cycles.
  - Required: `fetch_count`=4 after four handshakes.
- At `instr_pc`=3, handshake with `redirect`=1, `redirect_pc`=13 (beq target) → next `imem_addr`=13.
  - Required: `redirect`=1 pulsed with `redirect_pc`=5 while `instr_ready`=0 → ignored, next address 14.
- Ack delayed 15 cycles (MAX_WAIT=15) → accepted, no error.
  - Required: ack delayed 16 cycles → `timeout_err`=1 after cycle 15 and `imem_req`=0 thereafter.
  - Required: late ack → no change.
- `halt`=1 with handshake at pc=6, `redirect`=1, `redirect_pc`=2 → `halted`=1, pc=2, no further `imem_req`.
- `RESET_PC`=16383: first instruction fetched from 16383 → next `imem_addr`=0.
- Assert `rst_n`=0 mid-FETCH at pc=7 with ack arriving the same cycle → outputs at reset values immediately, fetch restarts at RESET_PC.
  - Required: hold `instr_ready`=0 for 40 cycles in VALID → `instr`/`instr_pc` stable, no timeout.
